// File: rtl/ask4_symbol_source.sv
// 4-ASK test-signal source: PRBS-driven Gray-mapped symbols or impulse/step/zero patterns,
// zero-stuffed (or held) up to the sample rate, as signed 1s17 samples.
`timescale 1ns/1ps

module ask4_symbol_source #(
  parameter int          LEVEL_HI   = 98304,
  parameter int          LEVEL_LO   = 32768,
  parameter logic [14:0] LFSR_SEED  = 15'h0001,
  parameter bit          ZERO_STUFF = 1'b1
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic [1:0]         mode,
  output logic signed [17:0] x_out,
  output logic [1:0]         sym_out,
  output logic               sym_strobe,
  output logic               align_err
);

  localparam logic [1:0] MODE_PRBS    = 2'd0;
  localparam logic [1:0] MODE_IMPULSE = 2'd1;
  localparam logic [1:0] MODE_STEP    = 2'd2;
  localparam logic [1:0] MODE_ZERO    = 2'd3;

  localparam logic signed [17:0] POS_HI = 18'(LEVEL_HI);
  localparam logic signed [17:0] POS_LO = 18'(LEVEL_LO);
  localparam logic signed [17:0] NEG_HI = -POS_HI;
  localparam logic signed [17:0] NEG_LO = -POS_LO;

  typedef enum logic {IDLE, FIRED} state_t;

  state_t             state_q, state_d;
  logic [14:0]        lfsr_q, lfsr_d;
  logic [1:0]         mode_q, mode_d;
  logic signed [17:0] x_d;
  logic [1:0]         sym_d;
  logic               strobe_d;
  logic               align_d;
  logic               sym_event;
  logic               sample_only;
  logic [1:0]         prbs_bits;
  logic [14:0]        lfsr_adv;

  assign sym_event   = sam_clk_en & sym_clk_en;
  assign sample_only = sam_clk_en & ~sym_clk_en;

  // Two Fibonacci steps at once: b1 is the first shifted-out bit, b0 the second.
  assign prbs_bits = lfsr_q[14:13];
  assign lfsr_adv  = {lfsr_q[12:0], lfsr_q[14] ^ lfsr_q[13], lfsr_q[13] ^ lfsr_q[12]};

  function automatic logic signed [17:0] gray_level(input logic [1:0] bits);
    case (bits)
      2'b00:   gray_level = NEG_HI;
      2'b01:   gray_level = NEG_LO;
      2'b11:   gray_level = POS_LO;
      default: gray_level = POS_HI;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    x_d      = x_out;
    sym_d    = sym_out;
    strobe_d = 1'b0;
    align_d  = align_err | (sym_clk_en & ~sam_clk_en);

    if (sym_event) begin
      mode_d   = mode;
      lfsr_d   = lfsr_adv;
      strobe_d = 1'b1;
      case (mode_d)
        MODE_PRBS: begin
          x_d   = gray_level(prbs_bits);
          sym_d = prbs_bits;
        end
        MODE_IMPULSE: begin
          x_d = '0;
          if (state_q == IDLE) begin
            state_d = FIRED;
            x_d     = POS_HI;
          end
        end
        MODE_STEP: x_d = POS_HI;
        MODE_ZERO: x_d = '0;
        default:   x_d = '0;
      endcase
      // Leaving impulse mode re-arms the single-shot pulse.
      if (mode_d != MODE_IMPULSE) state_d = IDLE;
    end else if (sample_only) begin
      if (ZERO_STUFF) x_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      mode_q     <= MODE_ZERO;
      x_out      <= '0;
      sym_out    <= 2'b00;
      sym_strobe <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      mode_q     <= mode_d;
      x_out      <= x_d;
      sym_out    <= sym_d;
      sym_strobe <= strobe_d;
      align_err  <= align_d;
    end
  end

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Bench for ask4_symbol_source: fixed vector table, reset/period corner cases and randomized
// strobes/modes against a bit-sequence reference model; zero-stuff and hold variants side by side.
`timescale 1ns/1ps

module tb_ask4_symbol_source;

  localparam logic [14:0] SEED = 15'h0001;
  localparam int HI = 98304;
  localparam int LO = 32768;
  localparam int PERIOD = 32767;
  localparam int NBITS = 70000;

  logic sys_clk = 1'b0;
  logic reset;
  logic sam_clk_en;
  logic sym_clk_en;
  logic [1:0] mode;

  logic signed [17:0] x_zs, x_hold;
  logic [1:0]         sym_zs, sym_hold;
  logic               strobe_zs, strobe_hold;
  logic               align_zs, align_hold;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 sys_clk = ~sys_clk;

  ask4_symbol_source #(.ZERO_STUFF(1'b1)) u_dut_zs (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .x_out(x_zs), .sym_out(sym_zs), .sym_strobe(strobe_zs), .align_err(align_zs)
  );

  ask4_symbol_source #(.ZERO_STUFF(1'b0)) u_dut_hold (
    .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .x_out(x_hold), .sym_out(sym_hold), .sym_strobe(strobe_hold), .align_err(align_hold)
  );

  // Reference PRBS as a flat bit sequence: b[n] = b[n-15] ^ b[n-14], first 15 bits = seed MSB first.
  bit prbs[NBITS];

  int   m_x, m_xh, m_sym, m_mode, m_pos;
  logic m_strobe, m_align, m_fired;

  typedef struct {
    logic       sam;
    logic       sym;
    logic [1:0] md;
    int         exp_x;
    int         exp_xh;
    int         exp_sym;
    logic       exp_strobe;
    logic       exp_align;
  } vec_t;

  vec_t vecs[16];

  function automatic int ref_level(input int b1, input int b0);
    if (b1 == 0 && b0 == 0) return -HI;
    if (b1 == 0 && b0 == 1) return -LO;
    if (b1 == 1 && b0 == 1) return LO;
    return HI;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_xh = 0; m_sym = 0; m_strobe = 1'b0; m_align = 1'b0;
    m_mode = 3; m_fired = 1'b0; m_pos = 0;
  endtask

  task automatic model_update(input logic sam, input logic sym, input logic [1:0] md);
    int b1, b0;
    if (sam && sym) begin
      b1 = int'(prbs[m_pos]);
      b0 = int'(prbs[m_pos + 1]);
      m_pos += 2;
      m_mode = int'(md);
      m_strobe = 1'b1;
      case (m_mode)
        0: begin m_x = ref_level(b1, b0); m_sym = b1 * 2 + b0; end
        1: begin m_x = m_fired ? 0 : HI; m_fired = 1'b1; end
        2: m_x = HI;
        default: m_x = 0;
      endcase
      if (m_mode != 1) m_fired = 1'b0;
      m_xh = m_x;
    end else begin
      m_strobe = 1'b0;
      if (sam) m_x = 0;
      if (sym && !sam) m_align = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic apply_stimulus(input logic sam, input logic sym, input logic [1:0] md);
    sam_clk_en = sam;
    sym_clk_en = sym;
    mode       = md;
    @(posedge sys_clk);
    model_update(sam, sym, md);
    @(negedge sys_clk);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_x"},      int'(x_zs),        m_x);
    check_output({tag, "_xhold"},  int'(x_hold),      m_xh);
    check_output({tag, "_sym"},    int'(sym_zs),      m_sym);
    check_output({tag, "_strobe"}, int'(strobe_zs),   int'(m_strobe));
    check_output({tag, "_align"},  int'(align_hold),  int'(m_align));
  endtask

  task automatic apply_vec(input int i);
    apply_stimulus(vecs[i].sam, vecs[i].sym, vecs[i].md);
    check_output($sformatf("vec%0d_x", i),      int'(x_zs),       vecs[i].exp_x);
    check_output($sformatf("vec%0d_xhold", i),  int'(x_hold),     vecs[i].exp_xh);
    check_output($sformatf("vec%0d_sym", i),    int'(sym_zs),     vecs[i].exp_sym);
    check_output($sformatf("vec%0d_strobe", i), int'(strobe_zs),  int'(vecs[i].exp_strobe));
    check_output($sformatf("vec%0d_align", i),  int'(align_zs),   int'(vecs[i].exp_align));
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b0;
    sam_clk_en = 1'b0; sym_clk_en = 1'b0; mode = 2'd0;
    model_reset();
    @(negedge sys_clk);
    reset = 1'b1;
  endtask

  initial begin
    int errs, nseen, others;
    bit seen[4];
    int sym_hist[PERIOD + 4];

    for (int n = 0; n < NBITS; n++)
      prbs[n] = (n < 15) ? bit'(SEED[14 - n]) : prbs[n - 15] ^ prbs[n - 14];

    vecs[0]  = '{1'b1, 1'b1, 2'd0, -HI, -HI, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0,   0, -HI, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0,   0, -HI, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3,   0, -HI, 0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'd3,   0,   0, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1,   0,   0, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd1,  HI,  HI, 0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd1,   0,  HI, 0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd1,   0,   0, 0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd3,   0,   0, 0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd1,  HI,  HI, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 2'd2,  HI,  HI, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2,   0,  HI, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd2,   0,  HI, 0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 2'd0,  HI,  HI, 2, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 2'd0,   0,  HI, 2, 1'b0, 1'b1};

    reset = 1'b0;
    sam_clk_en = 1'b0; sym_clk_en = 1'b0; mode = 2'd0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_output("rst_x",      int'(x_zs),      0);
    check_output("rst_sym",    int'(sym_zs),    0);
    check_output("rst_strobe", int'(strobe_zs), 0);
    check_output("rst_align",  int'(align_zs),  0);
    reset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 16; i++) apply_vec(i);

    // Asynchronous reset mid-symbol, then the stream restarts from the seed.
    #2 reset = 1'b0;
    #1;
    check_output("async_rst_xhold", int'(x_hold),   0);
    check_output("async_rst_sym",   int'(sym_zs),   0);
    check_output("async_rst_align", int'(align_zs), 0);
    @(negedge sys_clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) apply_vec(i);

    // Step mode at the 4:1 rate: 98304,0,0,0 stuffed vs constant when held.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, (k % 4) == 0, 2'd2);
      check_output($sformatf("step%0d_x", k),     int'(x_zs),   (k % 4) == 0 ? HI : 0);
      check_output($sformatf("step%0d_xhold", k), int'(x_hold), HI);
    end

    $display("[TB] randomized strobes and modes");
    do_reset();
    model_reset();
    mode = 2'd0;
    for (int k = 0; k < 500; k++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mode;
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, md);
      check_model($sformatf("rnd%0d", k));
    end

    $display("[TB] full PRBS period");
    do_reset();
    errs = 0; others = 0;
    for (int j = 0; j < 4; j++) seen[j] = 1'b0;
    for (int k = 0; k < PERIOD + 4; k++) begin
      apply_stimulus(1'b1, 1'b1, 2'd0);
      if (int'(x_zs) != m_x || int'(x_hold) != m_xh || int'(sym_zs) != m_sym) errs++;
      sym_hist[k] = int'(sym_zs);
      case (int'(x_zs))
        -HI:     seen[0] = 1'b1;
        -LO:     seen[1] = 1'b1;
        LO:      seen[2] = 1'b1;
        HI:      seen[3] = 1'b1;
        default: others++;
      endcase
    end
    check_output("prbs_model_mismatches", errs, 0);
    for (int k = 0; k < 4; k++)
      check_output($sformatf("prbs_period%0d", k), sym_hist[k + PERIOD], sym_hist[k]);
    nseen = 0;
    for (int j = 0; j < 4; j++) nseen += int'(seen[j]);
    check_output("prbs_level_count", nseen, 4);
    check_output("prbs_other_levels", others, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
